// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 streaming pooling block.
//   POOL_MAX / POOL_AVG : values of the mode input
//   DEF_*               : default DATA_W, IMG_W and IMG_H parameters
//   cnt_w()             : counter width needed to count 0..n-1 (at least 1 bit)
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IMG_W  = 8;
  localparam int DEF_IMG_H  = 8;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_pair_op.sv
// Combinational pairwise combine used for both the horizontal (pixel pair)
// and vertical (row pair) stages of the pooling window.
//   a, b : operands, zero-extended to DATA_W+2 bits by the caller
//   mode : POOL_MAX -> larger operand, POOL_AVG -> unsigned sum
//   y    : result, DATA_W+2 bits so a four-pixel sum never overflows
module pool_pair_op
  import pool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W+1:0] a,
  input  logic [DATA_W+1:0] b,
  input  logic              mode,
  output logic [DATA_W+1:0] y
);

  always_comb begin
    y = '0;
    if (mode == POOL_AVG) begin
      y = a + b;
    end else begin
      y = (a > b) ? a : b;
    end
  end

endmodule

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 max/average pooling over raster-order frames.
//   Clock, Reset_n     : clock and asynchronous active-low reset
//   mode               : POOL_MAX / POOL_AVG, captured with pixel (0,0)
//   s_valid/s_ready/s_data : input pixel stream (valid/ready)
//   m_valid/m_ready/m_data : pooled result stream, registered
//   m_last             : flags the final result of each frame
// Even rows leave their horizontal pair results in a half-width line
// buffer; odd rows combine with it and emit one result per pixel pair.
module pool2x2_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam int BW = cnt_w(IMG_W / 2);

  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  logic [DATA_W-1:0] pair_reg;
  logic              mode_frm;
  logic [DATA_W:0]   line_buf [IMG_W/2];

  logic              accept;
  logic              col_end;
  logic              row_end;
  logic              produce;
  logic [BW-1:0]     half_col;
  logic [DATA_W+1:0] h_val;
  logic [DATA_W+1:0] v_val;
  logic [DATA_W-1:0] res_data;

  assign s_ready  = !m_valid || m_ready;
  assign accept   = s_valid && s_ready;
  assign col_end  = (col_cnt == CW'(IMG_W - 1));
  assign row_end  = (row_cnt == RW'(IMG_H - 1));
  assign produce  = accept && col_cnt[0] && row_cnt[0];
  assign half_col = BW'(col_cnt >> 1);

  pool_pair_op #(.DATA_W(DATA_W)) u_h_op (
    .a    ({2'b00, pair_reg}),
    .b    ({2'b00, s_data}),
    .mode (mode_frm),
    .y    (h_val)
  );

  pool_pair_op #(.DATA_W(DATA_W)) u_v_op (
    .a    ({1'b0, line_buf[half_col]}),
    .b    (h_val),
    .mode (mode_frm),
    .y    (v_val)
  );

  // Average divides the four-pixel sum by 4 with a plain shift (floor).
  always_comb begin
    res_data = v_val[DATA_W-1:0];
    if (mode_frm == POOL_AVG) begin
      res_data = v_val[DATA_W+1:2];
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      pair_reg <= '0;
      mode_frm <= POOL_MAX;
    end else if (accept) begin
      if (col_cnt == '0 && row_cnt == '0) begin
        mode_frm <= mode;
      end
      if (!col_cnt[0]) begin
        pair_reg <= s_data;
      end
      if (col_end) begin
        col_cnt <= '0;
        row_cnt <= row_end ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Every entry is written on an even row before the odd row reads it,
  // so the buffer needs no reset.
  always_ff @(posedge Clock) begin
    if (accept && col_cnt[0] && !row_cnt[0]) begin
      line_buf[half_col] <= h_val[DATA_W:0];
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (produce) begin
      m_valid <= 1'b1;
      m_data  <= res_data;
      m_last  <= col_end && row_end;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
module tb_pool2x2_stream;
  import pool_pkg::*;

  localparam int DW   = 8;
  localparam int IW   = 4;
  localparam int IH   = 2;
  localparam int NPIX = IW * IH;

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          mode;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  bit mr_dir;
  bit rand_bp;
  bit rnd_bit;
  assign m_ready = rand_bp ? rnd_bit : mr_dir;

  int total = 0;
  int bad = 0;
  int px_idx = 0;
  int n_last = 0;
  int n_frames = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  pool2x2_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .mode    (mode),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  always #5 Clock = ~Clock;

  initial forever begin
    @(posedge Clock);
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  // Output scoreboard: inputs are stable from posedge+1, so a handshake
  // seen at the falling edge is the transfer at the next rising edge.
  always @(negedge Clock) begin
    exp_t e;
    if (Reset_n && m_valid && m_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_out: got data=%0d last=%0b, required no output", m_data, m_last);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        assert (m_data === e.d) else begin
          bad++;
          $error("FAIL out_data: got %0d, required %0d", m_data, e.d);
        end
        total++;
        assert (m_last === e.last) else begin
          bad++;
          $error("FAIL out_last: got %0b, required %0b", m_last, e.last);
        end
        if (m_last === 1'b1) n_last++;
      end
    end
  end

  // Reference: pool each 2x2 window of the frame directly.
  function automatic void model(input logic [DW-1:0] pix [NPIX], input logic md);
    for (int br = 0; br < IH / 2; br++) begin
      for (int bc = 0; bc < IW / 2; bc++) begin
        int v [4];
        int mx;
        int sum;
        exp_t e;
        v[0] = int'(pix[(2*br)*IW + 2*bc]);
        v[1] = int'(pix[(2*br)*IW + 2*bc + 1]);
        v[2] = int'(pix[(2*br+1)*IW + 2*bc]);
        v[3] = int'(pix[(2*br+1)*IW + 2*bc + 1]);
        mx = 0;
        sum = 0;
        for (int k = 0; k < 4; k++) begin
          if (v[k] > mx) mx = v[k];
          sum += v[k];
        end
        e.d = (md == POOL_AVG) ? DW'(sum / 4) : DW'(mx);
        e.last = (br == IH/2 - 1) && (bc == IW/2 - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic push(input logic [DW-1:0] d);
    int guard;
    int pos;
    bit accepted;
    guard = 0;
    accepted = 0;
    s_valid = 1'b1;
    s_data = d;
    while (!accepted && guard < 200) begin
      @(negedge Clock);
      if (s_ready === 1'b1) accepted = 1;
      @(posedge Clock);
      #1;
      guard++;
    end
    s_valid = 1'b0;
    total++;
    assert (accepted) else begin
      bad++;
      $error("FAIL push_timeout: s_ready got %0b, required 1", s_ready);
    end
    pos = px_idx % NPIX;
    if (accepted && ((pos / IW) % 2 == 1) && ((pos % IW) % 2 == 1)) begin
      total++;
      assert (m_valid === 1'b1) else begin
        bad++;
        $error("FAIL latency: m_valid got %0b one cycle after pixel %0d, required 1", m_valid, pos);
      end
    end
    px_idx++;
  endtask

  task automatic send_frame(input logic [DW-1:0] pix [NPIX], input logic md, input int flip_at);
    model(pix, md);
    mode = md;
    for (int i = 0; i < NPIX; i++) begin
      push(pix[i]);
      if (i == flip_at) mode = ~md;
    end
    n_frames++;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge Clock);
      #1;
      guard++;
    end
    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    s_valid = 1'b0;
    repeat (2) begin
      @(negedge Clock);
      total++;
      assert (m_valid === 1'b0) else begin
        bad++;
        $error("FAIL rst_m_valid: got %0b, required 0", m_valid);
      end
      total++;
      assert (m_last === 1'b0) else begin
        bad++;
        $error("FAIL rst_m_last: got %0b, required 0", m_last);
      end
      total++;
      assert (m_data === '0) else begin
        bad++;
        $error("FAIL rst_m_data: got %0d, required 0", m_data);
      end
      total++;
      assert (s_ready === 1'b1) else begin
        bad++;
        $error("FAIL rst_s_ready: got %0b, required 1", s_ready);
      end
      @(posedge Clock);
      #1;
    end
    exp_q.delete();
    px_idx = 0;
    Reset_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] f [NPIX];
    logic [DW-1:0] g [NPIX];
    Reset_n = 1'b0;
    mode = POOL_MAX;
    s_valid = 1'b0;
    s_data = '0;
    mr_dir = 1'b1;
    rand_bp = 1'b0;
    @(posedge Clock);
    #1;
    do_reset();

    // Directed max and average frames.
    f = '{8'd1, 8'd5, 8'd2, 8'd2, 8'd3, 8'd0, 8'd9, 8'd8};
    send_frame(f, POOL_MAX, -1);
    drain();
    send_frame(f, POOL_AVG, -1);
    drain();

    // Saturated average: sum 1020 must not wrap.
    for (int i = 0; i < NPIX; i++) f[i] = 8'd255;
    send_frame(f, POOL_AVG, -1);
    drain();

    // Backpressure on the first result for five cycles.
    f = '{8'd7, 8'd3, 8'd1, 8'd4, 8'd2, 8'd6, 8'd5, 8'd8};
    model(f, POOL_MAX);
    mode = POOL_MAX;
    for (int i = 0; i < 6; i++) push(f[i]);
    mr_dir = 1'b0;
    s_valid = 1'b1;
    s_data = f[6];
    repeat (5) begin
      @(negedge Clock);
      total++;
      assert (s_ready === 1'b0) else begin
        bad++;
        $error("FAIL stall_s_ready: got %0b, required 0", s_ready);
      end
      total++;
      assert (m_valid === 1'b1) else begin
        bad++;
        $error("FAIL stall_m_valid: got %0b, required 1", m_valid);
      end
      total++;
      assert (m_data === 8'd7) else begin
        bad++;
        $error("FAIL stall_m_data: got %0d, required 7", m_data);
      end
      @(posedge Clock);
      #1;
    end
    mr_dir = 1'b1;
    push(f[6]);
    push(f[7]);
    n_frames++;
    drain();

    // Reset mid-frame, then a clean frame 10..17.
    mode = POOL_MAX;
    push(8'd200);
    push(8'd201);
    push(8'd202);
    do_reset();
    f = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
    send_frame(f, POOL_MAX, -1);
    drain();

    // Back-to-back frames; mode toggled in the middle of the first.
    f = '{8'd4, 8'd8, 8'd20, 8'd0, 8'd0, 8'd0, 8'd1, 8'd3};
    g = '{8'd4, 8'd8, 8'd20, 8'd0, 8'd0, 8'd0, 8'd1, 8'd3};
    send_frame(f, POOL_MAX, 2);
    send_frame(g, POOL_AVG, -1);
    drain();

    // Random frames, random modes and random downstream backpressure.
    rand_bp = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NPIX; i++) f[i] = DW'($urandom_range(0, 255));
      send_frame(f, logic'($urandom_range(0, 1)), int'($urandom_range(0, NPIX - 1)));
    end
    drain();
    rand_bp = 1'b0;

    total++;
    assert (n_last == n_frames) else begin
      bad++;
      $error("FAIL last_count: got %0d, required %0d", n_last, n_frames);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
